sha256_stream_engine: RTL and testbench

//  Parametrised multi-block SHA-256 core for the miner datapath; successor to the fixed 640-bit engine.

---
 rtl/sha256_pkg.sv | 70 +++++++
 rtl/sha256_round.sv | 22 ++
 rtl/sha256_stream_engine.sv | 145 ++++++++++++++
 tb/tb_sha256_stream_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, initial hash value,
// FSM state encoding and the FIPS 180-4 bit-mixing helper functions.
package sha256_pkg;

   typedef logic [31:0] word_t;
   // Element 0 sits in the most significant bits (a / H0 first).
   typedef logic [0:7][31:0] hvec_t;

   typedef enum logic [2:0] {
      IDLE, LOAD, ROUND, ACCUM, DONE
   } state_t;

   localparam hvec_t IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam word_t K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic word_t rotr(word_t x, int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t ch(word_t x, word_t y, word_t z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic word_t maj(word_t x, word_t y, word_t z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic word_t bsig0(word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t bsig1(word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t ssig0(word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t ssig1(word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Message + 1 marker bit + 64-bit length, rounded up to 512-bit chunks.
   function automatic int num_blocks(int msg_bits);
      return (msg_bits + 64 + 1 + 511) / 512;
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
// Ports: st_i (a..h), w_i (W_t), k_i (K_t) -> st_o (next a..h).
module sha256_round
   import sha256_pkg::*;
(
   input  hvec_t st_i,
   input  word_t w_i,
   input  word_t k_i,
   output hvec_t st_o
);

   word_t t1;
   word_t t2;

   assign t1 = st_i[7] + bsig1(st_i[4])
             + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
   assign t2 = bsig0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);

   assign st_o = {t1 + t2, st_i[0], st_i[1], st_i[2],
                  st_i[3] + t1, st_i[4], st_i[5], st_i[6]};

endmodule

// File: rtl/sha256_stream_engine.sv
// Multi-block SHA-256 engine: pads MSG_BITS internally, one round/cycle.
// Ports: clk, rst (sync, active high), in_valid/in_ready/msg (input
// handshake), out_valid/out_ready/digest (result handshake), busy.
// Optional SHA_MIDSTATE_EN adds midstate_use/midstate to skip block 0.
module sha256_stream_engine
   import sha256_pkg::*;
#(
   parameter int MSG_BITS = 640
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MSG_BITS-1:0] msg,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [255:0]        digest,
`ifdef SHA_MIDSTATE_EN
   input  logic                midstate_use,
   input  logic [255:0]        midstate,
`endif
   output logic                busy
);

   localparam int NB  = num_blocks(MSG_BITS);
   localparam int BUF = NB * 512;
   localparam int ZB  = BUF - MSG_BITS - 65;
   localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

`ifdef SHA_MIDSTATE_EN
   if (NB < 2) begin : g_nb_chk
      $error("midstate skip needs at least two blocks");
   end
`endif

   state_t            state_q, state_d;
   logic [BUF-1:0]    buf_q, buf_d;
   logic [BW-1:0]     blk_q, blk_d;
   logic [5:0]        rnd_q, rnd_d;
   logic [0:15][31:0] w_q, w_d;
   hvec_t             wv_q, wv_d;
   hvec_t             h_q, h_d;
   logic [255:0]      digest_q, digest_d;

   logic [BUF-1:0] pad;
   logic [511:0]   chunk;
   word_t          w_new;
   hvec_t          wv_nxt;

   assign pad   = {msg, 1'b1, {ZB{1'b0}}, 64'(MSG_BITS)};
   // Chunk 0 holds the first message bits, i.e. the top of the buffer.
   assign chunk = buf_q[(NB - 1 - int'(blk_q)) * 512 +: 512];

   // Window holds W[t..t+15]; each round appends W[t+16].
   assign w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

   sha256_round u_round (
      .st_i (wv_q),
      .w_i  (w_q[0]),
      .k_i  (K[rnd_q]),
      .st_o (wv_nxt)
   );

   always_comb begin
      state_d  = state_q;
      buf_d    = buf_q;
      blk_d    = blk_q;
      rnd_d    = rnd_q;
      w_d      = w_q;
      wv_d     = wv_q;
      h_d      = h_q;
      digest_d = digest_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = LOAD;
               buf_d   = pad;
               h_d     = IV;
               blk_d   = '0;
`ifdef SHA_MIDSTATE_EN
               if (midstate_use) begin
                  h_d   = midstate;
                  blk_d = BW'(1);
               end
`endif
            end
         end
         LOAD: begin
            w_d     = chunk;
            wv_d    = h_q;
            rnd_d   = '0;
            state_d = ROUND;
         end
         ROUND: begin
            wv_d  = wv_nxt;
            w_d   = {w_q[1:15], w_new};
            rnd_d = rnd_q + 6'd1;
            if (rnd_q == 6'd63) state_d = ACCUM;
         end
         ACCUM: begin
            for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
            if (blk_q == BW'(NB - 1)) begin
               state_d  = DONE;
               digest_d = h_d;
            end else begin
               blk_d   = blk_q + BW'(1);
               state_d = LOAD;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         blk_q    <= '0;
         rnd_q    <= '0;
         h_q      <= IV;
         digest_q <= '0;
      end else begin
         state_q  <= state_d;
         blk_q    <= blk_d;
         rnd_q    <= rnd_d;
         h_q      <= h_d;
         digest_q <= digest_d;
      end
   end

   // Pure datapath; always reloaded before use.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
      w_q   <= w_d;
      wv_q  <= wv_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign digest    = digest_q;

endmodule

// File: tb/tb_sha256_stream_engine.sv
// Randomised self-checking bench for sha256_stream_engine.
// Byte-level SHA-256 reference model; three parameterisations.
module tb_sha256_stream_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic         v24 = 0, or24 = 1, ir24, ov24, b24;
   logic [23:0]  m24 = '0;
   logic [255:0] d24;

   logic         v448 = 0, or448 = 1, ir448, ov448, b448;
   logic [447:0] m448 = '0;
   logic [255:0] d448;

   logic         v640 = 0, or640 = 1, ir640, ov640, b640;
   logic [639:0] m640 = '0;
   logic [255:0] d640;

   sha256_stream_engine #(.MSG_BITS(24)) u_dut24 (
      .clk(clk), .rst(rst), .in_valid(v24), .in_ready(ir24),
      .msg(m24), .out_valid(ov24), .out_ready(or24),
      .digest(d24), .busy(b24)
   );

   sha256_stream_engine #(.MSG_BITS(448)) u_dut448 (
      .clk(clk), .rst(rst), .in_valid(v448), .in_ready(ir448),
      .msg(m448), .out_valid(ov448), .out_ready(or448),
      .digest(d448), .busy(b448)
   );

   sha256_stream_engine #(.MSG_BITS(640)) u_dut640 (
      .clk(clk), .rst(rst), .in_valid(v640), .in_ready(ir640),
      .msg(m640), .out_valid(ov640), .out_ready(or640),
      .digest(d640), .busy(b640)
   );

   task automatic check(input string tag,
                        input logic [255:0] got,
                        input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(logic [31:0] x, int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook SHA-256 over a byte queue with a full 64-word schedule.
   function automatic logic [255:0] sha_ref(input logic [4095:0] m,
                                            input int nbits);
      byte unsigned q[$];
      logic [31:0] w[64];
      logic [31:0] hh[8];
      logic [31:0] s[8];
      logic [31:0] t1, t2;
      logic [63:0] len;
      len = 64'(nbits);
      for (int i = 0; i < nbits / 8; i++)
         q.push_back(m[nbits - 1 - 8 * i -: 8]);
      q.push_back(8'h80);
      while (q.size() % 64 != 56) q.push_back(8'h00);
      for (int i = 7; i >= 0; i--) q.push_back(len[8 * i +: 8]);
      for (int i = 0; i < 8; i++) hh[i] = sha256_pkg::IV[i];
      for (int b = 0; b < q.size() / 64; b++) begin
         for (int t = 0; t < 16; t++)
            w[t] = {q[64*b+4*t], q[64*b+4*t+1],
                    q[64*b+4*t+2], q[64*b+4*t+3]};
         for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10))
                 + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3))
                 + w[t-16];
         s = hh;
         for (int t = 0; t < 64; t++) begin
            t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6]))
               + sha256_pkg::K[t] + w[t];
            t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            s[7] = s[6]; s[6] = s[5]; s[5] = s[4];
            s[4] = s[3] + t1;
            s[3] = s[2]; s[2] = s[1]; s[1] = s[0];
            s[0] = t1 + t2;
         end
         for (int i = 0; i < 8; i++) hh[i] = hh[i] + s[i];
      end
      return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
   endfunction

   // All hash tasks are entered and left #1 after a rising edge.
   task automatic hash24(input logic [23:0] m,
                         output logic [255:0] dg, output int lat);
      int k = 0;
      m24 = m; v24 = 1;
      while (!ir24 && k < 400) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      v24 = 0; m24 = ~m;
      lat = 0;
      while (!ov24 && lat < 400) begin @(posedge clk); #1; lat++; end
      dg = d24;
   endtask

   task automatic hash448(input logic [447:0] m,
                          output logic [255:0] dg, output int lat);
      int k = 0;
      m448 = m; v448 = 1;
      while (!ir448 && k < 400) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      v448 = 0; m448 = ~m;
      lat = 0;
      while (!ov448 && lat < 400) begin @(posedge clk); #1; lat++; end
      dg = d448;
   endtask

   task automatic hash640(input logic [639:0] m,
                          output logic [255:0] dg, output int lat);
      int k = 0;
      m640 = m; v640 = 1;
      while (!ir640 && k < 400) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      v640 = 0; m640 = ~m;
      lat = 0;
      while (!ov640 && lat < 400) begin @(posedge clk); #1; lat++; end
      dg = d640;
   endtask

   localparam logic [255:0] ABC_D =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] L448_D =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   initial begin
      logic [255:0] dg, exp;
      logic [447:0] s448;
      logic [639:0] hdr;
      logic [4095:0] wide;
      int lat, k;

      repeat (3) @(posedge clk);
      #1 rst = 0;
      check("rst_in_ready", 256'(ir640), 256'(1));
      check("rst_out_valid", 256'(ov640), 256'(0));
      check("rst_busy", 256'(b640), 256'(0));
      check("rst_digest", d640, '0);

      hash24(24'h616263, dg, lat);
      check("abc_digest", dg, ABC_D);
      check("abc_latency", 256'(lat), 256'(66));
      wide = '0; wide[23:0] = 24'h616263;
      check("abc_model", sha_ref(wide, 24), ABC_D);

      // Abort mid-hash; the message waits out DONE first.
      m24 = 24'h616263; v24 = 1; k = 0;
      while (!ir24 && k < 400) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      v24 = 0;
      repeat (32) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1;
      rst = 0;
      check("abort_in_ready", 256'(ir24), 256'(1));
      check("abort_out_valid", 256'(ov24), 256'(0));
      check("abort_busy", 256'(b24), 256'(0));
      check("abort_digest", d24, '0);
      repeat (5) begin
         @(posedge clk); #1;
         check("abort_no_out", 256'(ov24), 256'(0));
      end
      hash24(24'h616263, dg, lat);
      check("rerun_digest", dg, ABC_D);
      check("rerun_latency", 256'(lat), 256'(66));

      s448 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
      hash448(s448, dg, lat);
      check("l448_digest", dg, L448_D);
      check("l448_latency", 256'(lat), 256'(132));

      // Back-to-back random 640-bit headers.
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 20; i++) hdr[32 * i +: 32] = $urandom();
         wide = '0; wide[639:0] = hdr;
         exp = sha_ref(wide, 640);
         hash640(hdr, dg, lat);
         check("hdr_digest", dg, exp);
         check("hdr_latency", 256'(lat), 256'(132));
      end

      // Backpressure on the result side.
      @(posedge clk); #1;
      or640 = 0;
      for (int i = 0; i < 20; i++) hdr[32 * i +: 32] = $urandom();
      wide = '0; wide[639:0] = hdr;
      exp = sha_ref(wide, 640);
      hash640(hdr, dg, lat);
      check("bp_digest", dg, exp);
      check("bp_latency", 256'(lat), 256'(132));
      v640 = 1;
      repeat (20) begin
         @(posedge clk); #1;
         check("bp_hold_digest", d640, exp);
         check("bp_hold_valid", 256'(ov640), 256'(1));
         check("bp_hold_in_ready", 256'(ir640), 256'(0));
      end
      v640 = 0;
      or640 = 1;
      @(posedge clk); #1;
      check("bp_release_in_ready", 256'(ir640), 256'(1));
      check("bp_release_valid", 256'(ov640), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
